// File: rtl/excess3_pkg.sv
// Shared constants, error-bit indices and state encoding for the excess-3
// frame accumulator slice.
package excess3_pkg;

  localparam logic [3:0] E3_OFFSET = 4'd3;
  localparam logic [3:0] E3_MIN    = 4'd3;
  localparam logic [3:0] E3_MAX    = 4'd12;

  localparam int ERR_CODE = 0;
  localparam int ERR_OVF  = 1;

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/excess3_frame_accumulator_if.sv
// Digit-in / result-out stream bundle for the excess-3 frame accumulator.
// The slave side is the accumulator, the master side feeds digits and drains results.
interface excess3_frame_accumulator_if #(
  parameter int OUT_W = 14,
  parameter int CW    = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_digit;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_value;
  logic [CW-1:0]    out_ndig;
  logic [1:0]       out_err;

  modport master (
    output in_valid, in_digit, in_last, out_ready,
    input  in_ready, out_valid, out_value, out_ndig, out_err
  );

  modport slave (
    input  in_valid, in_digit, in_last, out_ready,
    output in_ready, out_valid, out_value, out_ndig, out_err
  );
endinterface

// File: rtl/excess3_digit_check.sv
// Combinational excess-3 digit validator/decoder: illegal codes decode to 0
// with legal deasserted.
module excess3_digit_check
  import excess3_pkg::*;
(
  input  logic [3:0] code,
  output logic [3:0] d,
  output logic       legal
);

  // range check and offset removal
  always_comb begin
    d     = 4'd0;
    legal = 1'b0;
    if ((code >= E3_MIN) && (code <= E3_MAX)) begin
      legal = 1'b1;
      d     = code - E3_OFFSET;
    end else begin
      legal = 1'b0;
      d     = 4'd0;
    end
  end

endmodule

// File: rtl/excess3_frame_accumulator.sv
// Accumulates an MSD-first excess-3 digit frame into a binary value and holds
// the result with sticky error flags until the downstream consumes it.
module excess3_frame_accumulator
  import excess3_pkg::*;
#(
  parameter int NDIG  = 4,
  parameter int OUT_W = 14
) (
  input logic                    clk,
  input logic                    rst,
  excess3_frame_accumulator_if.slave bus
);

  localparam int CW = $clog2(NDIG + 1) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(NDIG);
  localparam logic [CW-1:0] CNT_SAT = CW'(NDIG + 1);

  state_t           state;
  state_t           state_next;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] acc_upd;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_upd;
  logic [1:0]       err;
  logic [1:0]       err_upd;
  logic [3:0]       d;
  logic             legal;
  logic             accept;

  excess3_digit_check u_check (
    .code  (bus.in_digit),
    .d     (d),
    .legal (legal)
  );

  // handshake strobes decode straight from the state flop, so no out_ready -> in_ready path
  assign bus.in_ready  = (state == ST_ACC);
  assign bus.out_valid = (state == ST_HOLD);
  assign accept        = bus.in_valid && bus.in_ready;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_ACC;
    end else begin
      state <= state_next;
    end
  end

  // next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_ACC: begin
        if (accept && bus.in_last) state_next = ST_HOLD;
        else                       state_next = ST_ACC;
      end
      ST_HOLD: begin
        if (bus.out_ready) state_next = ST_ACC;
        else               state_next = ST_HOLD;
      end
      default: state_next = ST_ACC;
    endcase
  end

  // accumulator candidate for the current beat; acc freezes once NDIG digits are in
  always_comb begin
    acc_upd = acc;
    cnt_upd = cnt;
    err_upd = err;
    if (!legal) err_upd[ERR_CODE] = 1'b1;
    else        err_upd[ERR_CODE] = err[ERR_CODE];
    if (cnt < CNT_MAX) begin
      acc_upd = (acc << 3) + (acc << 1) + OUT_W'(d);
      cnt_upd = cnt + CW'(1'b1);
    end else begin
      err_upd[ERR_OVF] = 1'b1;
      cnt_upd          = CNT_SAT;
    end
  end

  // frame datapath and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc           <= {OUT_W{1'b0}};
      cnt           <= {CW{1'b0}};
      err           <= 2'b00;
      bus.out_value <= {OUT_W{1'b0}};
      bus.out_ndig  <= {CW{1'b0}};
      bus.out_err   <= 2'b00;
    end else if (accept) begin
      acc <= acc_upd;
      cnt <= cnt_upd;
      err <= err_upd;
      if (bus.in_last) begin
        bus.out_value <= acc_upd;
        bus.out_ndig  <= cnt_upd;
        bus.out_err   <= err_upd;
      end
    end else if (bus.out_valid && bus.out_ready) begin
      acc <= {OUT_W{1'b0}};
      cnt <= {CW{1'b0}};
      err <= 2'b00;
    end
  end

endmodule

// File: tb/tb_excess3_frame_accumulator.sv
// Randomized and directed frames against a digit-list reference model of the
// excess-3 frame accumulator.
module tb_excess3_frame_accumulator;

  localparam int NDIG  = 4;
  localparam int OUT_W = 14;
  localparam int CW    = $clog2(NDIG + 1) + 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  excess3_frame_accumulator_if #(.OUT_W(OUT_W), .CW(CW)) bus ();

  excess3_frame_accumulator #(.NDIG(NDIG), .OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int frame[$];
  int exp_val, exp_ndig, exp_err;
  int obs_val, obs_ndig, obs_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: decode each code, build decimal value from the first NDIG digits.
  function automatic void model();
    int n;
    int dig;
    exp_val = 0;
    exp_err = 0;
    n       = 0;
    foreach (frame[i]) begin
      if (frame[i] >= 3 && frame[i] <= 12) dig = frame[i] - 3;
      else begin
        dig = 0;
        exp_err |= 1;
      end
      if (n < NDIG) begin
        exp_val = (exp_val * 10 + dig) % (1 << OUT_W);
        n++;
      end else begin
        exp_err |= 2;
        n = NDIG + 1;
      end
    end
    exp_ndig = n;
  endfunction

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      bus.in_valid = 1'b0;
      bus.in_digit = 4'($urandom_range(0, 15));
      bus.in_last  = 1'($urandom_range(0, 1));
      check("stall_in_ready", bus.in_ready, 1);
      step();
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 1);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_value"}, bus.out_value, 0);
    check({tag, "_out_ndig"}, bus.out_ndig, 0);
    check({tag, "_out_err"}, bus.out_err, 0);
  endtask

  task automatic send_frame(input int hold);
    int w;
    model();
    foreach (frame[i]) begin
      idle_cycles($urandom_range(0, 2));
      bus.in_valid = 1'b1;
      bus.in_digit = 4'(frame[i]);
      bus.in_last  = (i == frame.size() - 1);
      check("accept_in_ready", bus.in_ready, 1);
      step();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    w = 0;
    while (!bus.out_valid && w < 20) begin
      step();
      w++;
    end
    check("out_latency", w, 0);
    obs_val  = int'(bus.out_value);
    obs_ndig = int'(bus.out_ndig);
    obs_err  = int'(bus.out_err);
    check("out_value", obs_val, exp_val);
    check("out_ndig", obs_ndig, exp_ndig);
    check("out_err", obs_err, exp_err);
    check("hold_in_ready", bus.in_ready, 0);
    // push unwanted digits while held; none may be taken
    for (int k = 0; k < hold; k++) begin
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_digit  = 4'($urandom_range(0, 15));
      bus.in_last   = 1'($urandom_range(0, 1));
      step();
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_out_value", bus.out_value, exp_val);
      check("stall_out_ndig", bus.out_ndig, exp_ndig);
      check("stall_out_err", bus.out_err, exp_err);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("release_out_valid", bus.out_valid, 0);
    check("release_in_ready", bus.in_ready, 1);
  endtask

  task automatic async_reset(input string tag);
    rst = 1'b1;
    #1;
    check_reset_values(tag);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_digit  = 4'd0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    step();
    check_reset_values("post_reset");

    frame = '{4, 5, 6, 10};
    send_frame(0);
    check("dir_1237_value", obs_val, 1237);
    check("dir_1237_ndig", obs_ndig, 4);
    check("dir_1237_err", obs_err, 0);

    frame = '{12};
    send_frame(1);
    check("dir_single_value", obs_val, 9);
    check("dir_single_ndig", obs_ndig, 1);

    frame = '{3};
    send_frame(0);
    check("dir_zero_value", obs_val, 0);

    frame = '{5, 15, 4};
    send_frame(0);
    check("dir_illegal_value", obs_val, 201);
    check("dir_illegal_err", obs_err, 1);
    check("dir_illegal_ndig", obs_ndig, 3);

    frame = '{4, 4, 4, 4, 4};
    send_frame(0);
    check("dir_ovf_value", obs_val, 1111);
    check("dir_ovf_err", obs_err, 2);
    check("dir_ovf_ndig", obs_ndig, 5);

    frame = '{6, 9, 3};
    send_frame(5);
    check("dir_bp_value", obs_val, 360);
    frame = '{4};
    send_frame(0);
    check("dir_after_bp_value", obs_val, 1);

    // abort a frame after two digits
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b0;
    bus.in_digit = 4'd8;
    step();
    bus.in_digit = 4'd9;
    step();
    bus.in_valid = 1'b0;
    async_reset("mid_reset");
    step();
    frame = '{7};
    send_frame(0);
    check("dir_after_reset_value", obs_val, 4);
    check("dir_after_reset_err", obs_err, 0);
    check("dir_after_reset_ndig", obs_ndig, 1);

    // discard a pending result
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b1;
    bus.in_digit = 4'd11;
    step();
    bus.in_valid = 1'b0;
    check("hold_before_reset", bus.out_valid, 1);
    async_reset("hold_reset");
    step();

    for (int f = 0; f < 40; f++) begin
      int len;
      int v;
      frame.delete();
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 9) < 8) frame.push_back($urandom_range(3, 12));
        else begin
          v = $urandom_range(0, 5);
          frame.push_back(v < 3 ? v : v + 10);
        end
      end
      send_frame($urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/excess3_frame_accumulator.md
# excess3_frame_accumulator

Sequential stage directly downstream of the per-digit excess-3 decoder path. It accepts a stream of excess-3 digit codes (most-significant digit first, framed by `in_last`) over a valid/ready handshake, and validates and decodes each code. It accumulates the frame into a single unsigned binary value (`acc = acc*10 + digit`) and presents the result with error flags on a valid/ready output port.

## Interface
Parameters:
- `NDIG`, 4: maximum digits per frame.
- `OUT_W`, 14: result width. Must satisfy 10^NDIG − 1 < 2^OUT_W.

Ports:
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  `in_digit`/`in_last` valid.
- `in_ready`  output  1  block accepts a digit this cycle.
- `in_digit`  input  4  excess-3 code. Legal range 3..12.
- `in_last`  input  1  marks the final digit of a frame.
- `out_valid`  output  1  result held on output.
- `out_ready`  input  1  downstream consumes the result.
- `out_value`  output  OUT_W  binary value of the frame.
- `out_ndig`  output  $clog2(NDIG+1)+1  accepted digit count, saturating at NDIG+1.
- `out_err`  output  2  bit0 = illegal code seen; bit1 = more than NDIG digits.

## Operation
- States:
  - ACC (reset state): `in_ready`=1, `out_valid`=0.
  - HOLD: `in_ready`=0, `out_valid`=1.
- Accept: `in_valid && in_ready` on a rising edge of `clk`.
- Per accepted digit:
  - Decode `d = in_digit − 3` if 3 ≤ `in_digit` ≤ 12.
  - Otherwise `d = 0` and set `err[0]`.
- Accumulate:
  - If count < NDIG: `acc <= acc*10 + d`, computed modulo 2^OUT_W, and count increments.
  - If count ≥ NDIG: `acc` is frozen, `err[1]` is set, and count saturates at NDIG+1.
- Accept with `in_last`=1: the accumulator updates as above. Then latch `out_value`, `out_ndig` and `out_err` from the updated values, and go to HOLD.
- HOLD with `out_ready`=1: go to ACC, and clear `acc`, count and err. `out_*` data registers keep their values but are don't-care while `out_valid`=0.
- Error flags are sticky within a frame and cleared only at the frame boundary or on reset.
- `in_last` on the first digit gives a single-digit frame.
- A zero-digit frame is impossible: `in_last` always travels with a digit.
- `in_digit`/`in_last` are ignored when `in_valid`=0.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0, `out_value`=0, `out_ndig`=0, `out_err`=0.
  - Internal `acc`=0, count=0, err=0, state=ACC.
- Latency: `out_valid` rises on the clock edge that accepts the `in_last` digit, i.e. it is visible in the following cycle.
- Throughput:
  - One digit per cycle inside a frame.
  - One bubble cycle between frames: `in_ready` is low for every HOLD cycle and returns high the cycle after the output handshake.
- `out_valid`/`out_value`/`out_ndig`/`out_err` are stable while `out_valid`=1 and `out_ready`=0.
- `in_ready` is a pure function of state (registered); there is no combinational path from `out_ready` to `in_ready`.
- Reset asserted mid-frame or in HOLD:
  - Immediately (asynchronously) returns all of the reset values above.
  - The partial frame or the pending result is discarded.
- Count and `acc` updates happen only on accepted beats; stalls (`in_valid`=0) change nothing.

## Structure
- Shared package `excess3_pkg`:
  - `E3_OFFSET`=3, `E3_MIN`=3, `E3_MAX`=12.
  - Error bit indices `ERR_CODE`=0, `ERR_OVF`=1.
  - State encoding `ST_ACC`/`ST_HOLD`.
- Sub-module `excess3_digit_check`: combinational; 4-bit code in, 4-bit `d` plus `legal` out. It is instantiated once.
- Accumulator `*10` is implemented as `(acc<<3)+(acc<<1)`, truncated to OUT_W.

## Test plan
- Reset, then frame codes 4,5,6,10 (`last` on 10) → `out_value`=1237, `out_ndig`=4, `out_err`=00, `out_valid` one cycle after the last accept.
- Single digit 12 with `last` → `out_value`=9, `out_ndig`=1, `err`=00. Next frame 3 (last) → value 0.
- Illegal code: 5,15,4 (last) → `out_value`=201 (15 decodes as 0), `err`=01, `ndig`=3.
- Overflow with NDIG=4: 4,4,4,4,4 (last) → `out_value`=1111, `err`=10, `ndig`=5.
- Back-pressure: hold `out_ready`=0 for 5 cycles → outputs stable, `in_ready`=0 throughout. After `out_ready`=1, `in_ready`=1 next cycle and the next frame accumulates from 0.
- Reset after 2 digits of a frame → `in_ready`=1 and `out_valid`=0 immediately. Following frame 7 (last) → value 4, `err`=00, `ndig`=1.
